dmem_store_buffer_responder: RTL

- Responder end of the CPU data-memory interface: receives MEM-stage load/store requests and returns load data.
- Backs a single-port word array (one access per cycle) with a FIFO store buffer, so stores retire without blocking loads.
- Drives a stall back to the pipeline when it cannot accept a request.
- Sits beside the cpu top, wired to its dm_* ports plus a read enable and a stall return.

---
 rtl/dmem_store_buffer_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dmem_store_buffer_responder.sv
// ---------------------------------------------------------------------------
// dmem_store_buffer_responder
//
// Purpose:
//   Responder end of the CPU data-memory interface. A single-port word array
//   (one access per cycle) is fronted by a FIFO store buffer. Stores are
//   pushed into the buffer and retire to the array when the port is free,
//   so stores do not block loads. Loads are returned one cycle after
//   acceptance. A combinational stall is returned when a request cannot be
//   accepted this cycle.
//
// Optional feature macro:
//   DMEM_SB_BYPASS_EN - when defined, a load that matches a buffered store is
//   served from the youngest matching buffer entry without stalling. When
//   undefined (default), such a load stalls until the matching entries have
//   drained, then reads the array.
//
// Ports:
//   clock             system clock
//   reset             asynchronous, active-high reset
//   dm_read_enable    load request this cycle
//   dm_read_address   load byte address (bits [1:0] ignored)
//   dm_read_data      registered load data, held until the next accepted load
//   dm_write_enable   store request this cycle
//   dm_write_address  store byte address (bits [1:0] ignored)
//   dm_write_data     store data
//   dm_stall          request not accepted; requester holds inputs stable
//   sb_count          number of valid store buffer entries
//   sb_empty          store buffer holds no entries
// ---------------------------------------------------------------------------
module dmem_store_buffer_responder #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int DEPTH_LOG2   = 10,
  parameter int SB_DEPTH     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       dm_read_enable,
  input  logic [ADDRESS_SIZE-1:0]    dm_read_address,
  output logic [DATA_SIZE-1:0]       dm_read_data,
  input  logic                       dm_write_enable,
  input  logic [ADDRESS_SIZE-1:0]    dm_write_address,
  input  logic [DATA_SIZE-1:0]       dm_write_data,
  output logic                       dm_stall,
  output logic [$clog2(SB_DEPTH):0]  sb_count,
  output logic                       sb_empty
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORDS = 1 << DEPTH_LOG2;

  // Word array: no reset, contents survive reset.
  logic [DATA_SIZE-1:0]  r_mem [WORDS];

  // Store buffer storage (data path, not reset) and control (reset).
  logic [DEPTH_LOG2-1:0] r_sb_idx  [SB_DEPTH];
  logic [DATA_SIZE-1:0]  r_sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0]   r_sb_valid;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_SIZE-1:0]  r_rd_data;

  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic                  w_full;
  logic                  w_not_empty;
  logic                  w_match;
  logic                  w_hit;
  logic [DATA_SIZE-1:0]  w_hit_data;
  logic                  w_bypass;
  logic                  w_load_acc;
  logic                  w_store_acc;
  logic                  w_arr_read;
  logic                  w_drain;
  logic                  w_unused_addr;

  // Only the word index takes part in addressing and matching.
  assign w_rd_idx = dm_read_address[DEPTH_LOG2+1:2];
  assign w_wr_idx = dm_write_address[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^{dm_read_address, dm_write_address};

  assign w_full      = (r_count == CNT_W'(SB_DEPTH));
  assign w_not_empty = (r_count != '0);

  // Scan entries oldest to youngest starting at the read pointer; a later
  // match overwrites an earlier one, so the youngest matching data wins.
  always_comb begin
    w_match    = 1'b0;
    w_hit_data = '0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      if (r_sb_valid[r_rd_ptr + PTR_W'(k)] &&
          (r_sb_idx[r_rd_ptr + PTR_W'(k)] == w_rd_idx)) begin
        w_match    = 1'b1;
        w_hit_data = r_sb_data[r_rd_ptr + PTR_W'(k)];
      end
    end
  end

  assign w_hit = dm_read_enable & w_match;

`ifdef DMEM_SB_BYPASS_EN
  assign w_bypass = w_hit;
  assign dm_stall = w_full & (dm_read_enable | dm_write_enable);
`else
  // A load hitting a buffered store waits until that store has retired.
  assign w_bypass = 1'b0;
  assign dm_stall = (w_full & (dm_read_enable | dm_write_enable)) | w_hit;
`endif

  assign w_load_acc  = dm_read_enable  & ~dm_stall;
  assign w_store_acc = dm_write_enable & ~dm_stall;

  // Port arbitration. When full, any request stalls so no load can be
  // accepted, which lets the drain take the port ahead of array reads.
  assign w_arr_read = w_load_acc & ~w_bypass;
  assign w_drain    = w_full | (w_not_empty & ~w_arr_read);

  // Control state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_sb_valid <= '0;
      r_rd_data  <= '0;
    end else begin
      if (w_load_acc) begin
        r_rd_data <= w_bypass ? w_hit_data : r_mem[w_rd_idx];
      end
      // Push and pop never target the same slot: pop needs non-empty,
      // push needs non-full, and the pointers only coincide at those limits.
      if (w_drain) begin
        r_sb_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + 1'b1;
      end
      if (w_store_acc) begin
        r_sb_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_store_acc) - CNT_W'(w_drain);
    end
  end

  // Buffer entry payload.
  always_ff @(posedge clock) begin
    if (w_store_acc) begin
      r_sb_idx[r_wr_ptr]  <= w_wr_idx;
      r_sb_data[r_wr_ptr] <= dm_write_data;
    end
  end

  // Array write port, used only by drains. Reset clears the count, so no
  // drain happens on the edge after reset and pending stores are dropped.
  always_ff @(posedge clock) begin
    if (w_drain) begin
      r_mem[r_sb_idx[r_rd_ptr]] <= r_sb_data[r_rd_ptr];
    end
  end

  assign dm_read_data = r_rd_data;
  assign sb_count     = r_count;
  assign sb_empty     = (r_count == '0);

endmodule
